// File: rtl/ppfifo.sv
`timescale 1ns/1ps
// Ping-pong FIFO: writer fills one bank while reader drains the other; banks swap when read bank drains.
// Latency: put_ack/get_ack one cycle after req is seen; earliest get of a word is two cycles after its put accept.
// Backpressure: put waits while write bank is full and read bank holds data; get waits while read bank is empty.
//
// Ports:
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   clear                 synchronous flush of both banks, overrides all handshakes
//   put_req/put_value     4-phase writer request and its data word
//   put_ack               write accepted, held until put_req drops
//   get_req               4-phase reader request
//   get_ack/get_value     read accepted, word held stable (and after ack drops)
//   full                  write bank full and read bank not empty
//   empty                 both banks empty
module ppfifo #(
  parameter int FIFO_WORD_SIZE = 1,
  parameter int BANK_DEPTH     = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      clear,
  input  logic                      put_req,
  input  logic [FIFO_WORD_SIZE-1:0] put_value,
  output logic                      put_ack,
  input  logic                      get_req,
  output logic                      get_ack,
  output logic [FIFO_WORD_SIZE-1:0] get_value,
  output logic                      full,
  output logic                      empty
);

  localparam int PW = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BANK_DEPTH);

  typedef enum logic [1:0] {P_IDLE, P_ACK, P_DROP} put_state_t;
  typedef enum logic [1:0] {G_IDLE, G_ACK, G_DROP} get_state_t;

  put_state_t pstate;
  get_state_t gstate;

  // Both banks live in one array; the bank select is the top address bit.
  logic [FIFO_WORD_SIZE-1:0] mem [0:2*BANK_DEPTH-1];

  logic          wsel;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] wcnt;
  logic [CW-1:0] rcnt;

  logic [PW:0] waddr;
  logic [PW:0] raddr;
  logic        wfull;
  logic        rempty;
  logic        put_acc;
  logic        get_acc;
  logic        swap;

  assign waddr  = {wsel, wptr};
  assign raddr  = {~wsel, rptr};
  assign wfull  = (wcnt == DEPTH_C);
  assign rempty = (rcnt == '0);

  assign put_acc = !clear && (pstate == P_IDLE) && put_req && !wfull;
  assign get_acc = !clear && (gstate == G_IDLE) && get_req && !rempty;

  // Release the write bank once the reader has nothing left: either the bank
  // is full, or the writer is idle between requests (partial bank handoff).
  assign swap = !clear && rempty && (wcnt != '0) &&
                (wfull || ((pstate == P_IDLE) && !put_req)) &&
                !put_acc && !get_acc;

  assign full  = wfull && !rempty;
  assign empty = (wcnt == '0) && rempty;

  // Storage has no reset; occupancy is tracked by the counters.
  always_ff @(posedge clock) begin
    if (put_acc) begin
      mem[waddr] <= put_value;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wsel <= 1'b0;
      wptr <= '0;
      rptr <= '0;
      wcnt <= '0;
      rcnt <= '0;
    end else if (clear) begin
      wsel <= 1'b0;
      wptr <= '0;
      rptr <= '0;
      wcnt <= '0;
      rcnt <= '0;
    end else if (swap) begin
      wsel <= ~wsel;
      wptr <= '0;
      rptr <= '0;
      rcnt <= wcnt;
      wcnt <= '0;
    end else begin
      if (put_acc) begin
        wptr <= wptr + PW'(1);
        wcnt <= wcnt + CW'(1);
      end
      if (get_acc) begin
        rptr <= rptr + PW'(1);
        rcnt <= rcnt - CW'(1);
      end
    end
  end

  // Put handshake. P_DROP swallows a request that was live across a clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pstate  <= P_IDLE;
      put_ack <= 1'b0;
    end else if (clear) begin
      put_ack <= 1'b0;
      if (pstate == P_ACK) begin
        pstate <= P_DROP;
      end
    end else begin
      case (pstate)
        P_IDLE: begin
          if (put_acc) begin
            pstate  <= P_ACK;
            put_ack <= 1'b1;
          end
        end
        P_ACK: begin
          if (!put_req) begin
            pstate  <= P_IDLE;
            put_ack <= 1'b0;
          end
        end
        P_DROP: begin
          if (!put_req) begin
            pstate <= P_IDLE;
          end
        end
        default: begin
          pstate  <= P_IDLE;
          put_ack <= 1'b0;
        end
      endcase
    end
  end

  // Get handshake. get_value is only reloaded on an accept, so it holds
  // across ack release and clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gstate    <= G_IDLE;
      get_ack   <= 1'b0;
      get_value <= '0;
    end else if (clear) begin
      get_ack <= 1'b0;
      if (gstate == G_ACK) begin
        gstate <= G_DROP;
      end
    end else begin
      case (gstate)
        G_IDLE: begin
          if (get_acc) begin
            gstate    <= G_ACK;
            get_ack   <= 1'b1;
            get_value <= mem[raddr];
          end
        end
        G_ACK: begin
          if (!get_req) begin
            gstate  <= G_IDLE;
            get_ack <= 1'b0;
          end
        end
        G_DROP: begin
          if (!get_req) begin
            gstate <= G_IDLE;
          end
        end
        default: begin
          gstate  <= G_IDLE;
          get_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ppfifo.sv
`timescale 1ns/1ps
module tb_ppfifo;

  localparam int W      = 8;
  localparam int DEPTH  = 4;
  localparam int BUDGET = 60;

  logic         clock;
  logic         reset_n;
  logic         clear;
  logic         put_req;
  logic [W-1:0] put_value;
  logic         put_ack;
  logic         get_req;
  logic         get_ack;
  logic [W-1:0] get_value;
  logic         full;
  logic         empty;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain FIFO of accepted words, in acceptance order.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp = '0;

  ppfifo #(.FIFO_WORD_SIZE(W), .BANK_DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (clear),
    .put_req   (put_req),
    .put_value (put_value),
    .put_ack   (put_ack),
    .get_req   (get_req),
    .get_ack   (get_ack),
    .get_value (get_value),
    .full      (full),
    .empty     (empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: no response within %0d cycles", name, BUDGET);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_empty(input string name);
    check(name, {31'b0, empty}, {31'b0, (exp_q.size() == 0)});
  endtask

  // Full 4-phase put; the word enters the model when its ack is seen.
  task automatic do_put(input logic [W-1:0] v);
    int t;
    put_value = v;
    put_req   = 1'b1;
    t = 0;
    do begin
      idle(1);
      t++;
    end while (!put_ack && t < BUDGET);
    if (!put_ack) begin
      timeout("put ack rise");
      put_req = 1'b0;
      return;
    end
    exp_q.push_back(v);
    put_req = 1'b0;
    t = 0;
    do begin
      idle(1);
      t++;
    end while (put_ack && t < BUDGET);
    if (put_ack) timeout("put ack fall");
  endtask

  task automatic do_get();
    int t;
    get_req = 1'b1;
    t = 0;
    do begin
      idle(1);
      t++;
    end while (!get_ack && t < BUDGET);
    if (!get_ack) begin
      timeout("get ack rise");
      get_req = 1'b0;
      return;
    end
    get_req = 1'b0;
    t = 0;
    do begin
      idle(1);
      t++;
    end while (get_ack && t < BUDGET);
    if (get_ack) timeout("get ack fall");
  endtask

  // Monitor: each new get_ack presents one word; it must be the oldest in the model.
  initial begin
    bit prev;
    prev = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (get_ack && !prev) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL get data: got 0x%0h, expected no word", get_value);
        end else begin
          last_exp = exp_q.pop_front();
          check("get data", {24'b0, get_value}, {24'b0, last_exp});
        end
      end
      prev = get_ack;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset_n   = 1'b0;
    clear     = 1'b0;
    put_req   = 1'b0;
    put_value = '0;
    get_req   = 1'b0;
    idle(2);
    check("reset put_ack",   {31'b0, put_ack}, 0);
    check("reset get_ack",   {31'b0, get_ack}, 0);
    check("reset get_value", {24'b0, get_value}, 0);
    check("reset full",      {31'b0, full}, 0);
    check("reset empty",     {31'b0, empty}, 1);
    reset_n = 1'b1;
    idle(1);

    // Short burst then writer idles: partial bank is released.
    do_put(8'h01);
    do_put(8'h00);
    do_put(8'h01);
    idle(3);
    check_empty("empty after 3 puts");
    for (int i = 0; i < 3; i++) begin
      do_get();
      check("get_value hold", {24'b0, get_value}, {24'b0, last_exp});
      check_empty("empty during drain");
    end

    // Fill both banks; the ninth put must be held off.
    for (int i = 0; i < 2 * DEPTH; i++) do_put(8'h10 + 8'(i));
    check("full after two banks", {31'b0, full}, 1);
    put_value = 8'h18;
    put_req   = 1'b1;
    idle(6);
    check("ninth put withheld", {31'b0, put_ack}, 0);
    check("still full",         {31'b0, full}, 1);
    put_req = 1'b0;
    idle(2);
    for (int i = 0; i < 2 * DEPTH; i++) do_get();
    check_empty("empty after full drain");

    // Long-held request stores exactly one word.
    put_value = 8'hA5;
    put_req   = 1'b1;
    idle(1);
    check("put ack latency", {31'b0, put_ack}, 1);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check("put ack held", {31'b0, put_ack}, 1);
    end
    exp_q.push_back(8'hA5);
    put_req = 1'b0;
    idle(1);
    check("put ack release", {31'b0, put_ack}, 0);
    idle(3);
    check_empty("one held word present");
    do_get();
    check_empty("held put stored once");

    // Concurrent random traffic.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          idle($urandom_range(1, 4));
          do_put(8'($urandom_range(0, 255)));
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          idle($urandom_range(1, 4));
          do_get();
        end
      end
    join
    idle(2);
    check_empty("empty after random traffic");

    // Clear while a put is acknowledged and its request is still high.
    put_value = 8'h66;
    put_req   = 1'b1;
    t = 0;
    do begin
      idle(1);
      t++;
    end while (!put_ack && t < BUDGET);
    if (!put_ack) timeout("put ack before clear");
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    check("put ack after clear", {31'b0, put_ack}, 0);
    check("empty after clear",   {31'b0, empty}, 1);
    check("get_value kept over clear", {24'b0, get_value}, {24'b0, last_exp});
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("no re-accept after clear", {31'b0, put_ack}, 0);
      check("still empty after clear",  {31'b0, empty}, 1);
    end
    put_req = 1'b0;
    idle(2);
    do_put(8'h77);
    idle(3);
    do_get();
    check_empty("empty after post-clear word");

    // Reset in the middle of a get handshake.
    do_put(8'h3C);
    idle(3);
    get_req = 1'b1;
    t = 0;
    do begin
      idle(1);
      t++;
    end while (!get_ack && t < BUDGET);
    if (!get_ack) timeout("get ack before reset");
    idle(1);
    reset_n = 1'b0;
    #1;
    check("get_ack at reset",   {31'b0, get_ack}, 0);
    check("get_value at reset", {24'b0, get_value}, 0);
    check("empty at reset",     {31'b0, empty}, 1);
    get_req = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
    idle(2);
    check("empty after reset release", {31'b0, empty}, 1);
    check("full after reset release",  {31'b0, full}, 0);

    check("scoreboard drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
